// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder (with leaf cell full_adder)
// Description : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
//               using a single full_adder cell with a registered carry.
//               Optional signed-overflow output under SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf_out,
`endif
  output logic             cout_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_out  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_out <= {fa_sum, sum_out[WIDTH-1:1]};
          carry   <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            cout_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf_out  <= carry ^ fa_cout;
`endif
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8) with a
//               result scoreboard; ovf_out checked when SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_out;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .cout_out (cout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.ovf = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse pops and checks one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum_out", {24'd0, sum_out}, {24'd0, e.s});
        check("cout_out", {31'd0, cout_out}, {31'd0, e.co});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_out", {31'd0, ovf_out}, {31'd0, e.ovf});
`endif
      end
    end
  end

  // Drive a start for one cycle, then measure busy length and done latency
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic eco);
    exp_t e;
    int n;
    int busy_n;
    e = model(a, b, c);
    check("model_sum", {24'd0, e.s}, {24'd0, es});
    check("model_cout", {31'd0, e.co}, {31'd0, eco});
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end
    check("done_latency", n, W);
    check("busy_cycles", busy_n, W);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int dc;
    exp_t e;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, s: 8'h96, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h01, c: 1'b0, s: 8'h80, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'h10, b: 8'h20, c: 1'b0, s: 8'h30, co: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0};

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum_out}, 32'd0);
    check("rst_cout", {31'd0, cout_out}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", {31'd0, ovf_out}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_add(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      e = model(ra, rb, rc);
      run_add(ra, rb, rc, e.s, e.co);
    end

    // Start during the 3rd SHIFT cycle must be ignored
    dc = done_cnt;
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 8'h11; b_in = 8'h22; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 30) begin @(negedge clk); n++; end
    check("ignored_start_latency", n, W);
    repeat (12) @(negedge clk);
    check("ignored_start_single_done", done_cnt - dc, 1);

    // Back-to-back: start held through DONE
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h02; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
    n = 1;
    while (!done && n < 30) begin @(negedge clk); n++; end
    check("b2b_done_spacing", n, W + 1);
    check("b2b_sum", {24'd0, sum_out}, 32'h30);
    repeat (2) @(negedge clk);

    // Asynchronous reset during the 4th SHIFT cycle
    dc = done_cnt;
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sum", {24'd0, sum_out}, 32'd0);
    check("arst_cout", {31'd0, cout_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_done", done_cnt - dc, 0);
    run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder built around the existing single-bit full_adder cell. It accepts two WIDTH-bit operands plus a carry-in on a start pulse and processes one bit per clock, LSB first. The full_adder cell computes each bit, and a registered carry feeds back into its carry input. The block sits upstream of the full_adder cell, supplying its a/b/c inputs, and consumes its sum/cout outputs. It is the area-cheap adder for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, default 8: operand and result width in bits. Legal range is WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to load operands and begin an add. Sampled on the rising edge.
- a_in  input  WIDTH  operand A. Captured only on an accepted start.
- b_in  input  WIDTH  operand B. Captured only on an accepted start.
- cin  input  1  carry-in. Captured only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; the result is valid.
- sum_out  output  WIDTH  result register.
- cout_out  output  1  final carry-out.
- ovf_out  output  1  signed overflow. This port exists only with SERIAL_ADDER_OVF_EN.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The reset state is IDLE.
- Reset values: busy=0, done=0, sum_out=0, cout_out=0, ovf_out=0. All internal shift registers, the carry register and the bit counter are cleared.
- Accepting a start:
  - A start is accepted in IDLE or DONE; it is ignored in SHIFT.
  - On acceptance: a_in and b_in are loaded into shift registers A and B, the carry register takes cin, and the bit counter is cleared to 0.
  - The state moves to SHIFT and busy goes to 1.
- SHIFT, each cycle:
  - The full_adder inputs are a=A[0], b=B[0], c=carry.
  - On the clock edge: A and B shift right by 1. The full_adder sum shifts into sum_out[WIDTH-1] while sum_out shifts right. The carry register takes the full_adder cout. The counter increments.
- Leaving SHIFT:
  - On the edge that processes bit WIDTH-1 (counter = WIDTH-1), the state moves to DONE.
  - On that same edge: busy goes to 0, done goes to 1, and cout_out takes the full_adder cout.
- DONE lasts one cycle, with done=1.
  - The next state is IDLE, or SHIFT if start is high (back-to-back adds are allowed).
  - done deasserts on the following edge.
- Result hold:
  - sum_out and cout_out hold their values from DONE onward until the next accepted start.
  - During SHIFT, sum_out holds partial shift contents and is not valid.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1). This equals the unsigned sum.
- Reset asserted mid-operation aborts the add immediately. All outputs return to their reset values and no done pulse is produced.

## Timing
- Latency: a start accepted on edge k gives done=1 in the cycle after edge k+WIDTH. For WIDTH=8, done is seen after the 9th edge counting the start edge.
- Throughput: one add every WIDTH+1 cycles when started back-to-back from DONE, and every WIDTH+2 cycles when passing through IDLE.
- busy is high for exactly WIDTH cycles per add.
- All outputs are registered, with no combinational path from inputs to outputs.
- The full_adder cell is the only combinational logic in the bit path.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds the ovf_out port and a one-bit register that captures the carry into the MSB, i.e. the carry register value at counter = WIDTH-1.
  - On the transition to DONE, ovf_out = (carry into MSB) XOR (full_adder cout).
  - ovf_out holds its value like sum_out and resets to 0.
- SERIAL_ADDER_OVF_EN undefined: the ovf_out port and its register are absent; all other behaviour is identical.

## Test plan
- Basic add, WIDTH=8: a_in=0x5A, b_in=0x3C, cin=0, one-cycle start → busy high for 8 cycles, then done for one cycle with sum_out=0x96 and cout_out=0.
- Carry propagation: a_in=0xFF, b_in=0x01, cin=0 → sum_out=0x00, cout_out=1.
  - Also a_in=0xFF, b_in=0xFF, cin=1 → sum_out=0xFF, cout_out=1.
- Start ignored while busy: start asserted in the 3rd SHIFT cycle with different operands → the result is still the original sum; done pulses exactly once, and on schedule.
- Back-to-back: start held high through DONE with new operands 0x10 + 0x20 → the second add begins without passing through IDLE; the second done arrives 9 cycles after the first, with sum_out=0x30.
- Reset mid-operation: rst_n pulled low during the 4th SHIFT cycle → busy, done, sum_out and cout_out are 0 asynchronously; after release there is no done until a new start, and a new add of 0x01 + 0x01 gives 0x02.
- With SERIAL_ADDER_OVF_EN:
  - 0x7F + 0x01 → ovf_out=1, sum_out=0x80, cout_out=0.
  - 0x80 + 0x80 → ovf_out=1, cout_out=1, sum_out=0x00.
  - 0x10 + 0x20 → ovf_out=0.
